bscan_tap_ctrl: RTL and testbench

- IEEE 1149.1-style TAP controller that sequences the boundary-scan chain built from bscan_ff cells.
- Decodes TMS/TDI into the chain's shift, update, capture-enable and test-mode controls.
- Holds the instruction register, the bypass register and the IDCODE register.
- Sits between the chip-level test pins and the head/tail of the scan chain; the whole block runs on the single system clock.

---
 rtl/bscan_tap_ctrl.sv | 163 ++++++++++++++++
 tb/tb_bscan_tap_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bscan_tap_ctrl.sv
// TAP controller for a boundary-scan chain built from bscan_ff cells.
// It holds the instruction, bypass and IDCODE registers and decodes TMS/TDI into the chain controls.
module bscan_tap_ctrl #(
    parameter int                     IR_WIDTH     = 4,
    parameter logic [31:0]            IDCODE_VALUE = 32'h1876_5001,
    parameter logic [IR_WIDTH-1:0]    OP_EXTEST    = 4'b0000,
    parameter logic [IR_WIDTH-1:0]    OP_SAMPLE    = 4'b0001,
    parameter logic [IR_WIDTH-1:0]    OP_IDCODE    = 4'b0010
) (
    input  logic clock,
    input  logic reset_l,
    input  logic tms,
    input  logic tdi,
    output logic tdo,
    output logic tdo_oe,
    output logic bs_scan_in,
    input  logic bs_scan_out,
    output logic bs_shift,
    output logic bs_clock_en,
    output logic bs_update,
    output logic bs_test
);

    typedef enum logic [3:0] {
        TLR      = 4'd0,
        RTI      = 4'd1,
        SEL_DR   = 4'd2,
        CAP_DR   = 4'd3,
        SHIFT_DR = 4'd4,
        EXIT1_DR = 4'd5,
        PAUSE_DR = 4'd6,
        EXIT2_DR = 4'd7,
        UPD_DR   = 4'd8,
        SEL_IR   = 4'd9,
        CAP_IR   = 4'd10,
        SHIFT_IR = 4'd11,
        EXIT1_IR = 4'd12,
        PAUSE_IR = 4'd13,
        EXIT2_IR = 4'd14,
        UPD_IR   = 4'd15
    } tap_state_t;

    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

    tap_state_t          state_r;
    tap_state_t          state_nxt_s;
    logic [IR_WIDTH-1:0] ir_shift_r;
    logic [IR_WIDTH-1:0] ir_active_r;
    logic                bypass_r;
    logic [31:0]         idreg_r;
    logic                bsel_s;
    logic                idsel_s;

    // Unlisted opcodes fall through to BYPASS, so only boundary and IDCODE need decoding.
    assign bsel_s  = (ir_active_r == OP_EXTEST) || (ir_active_r == OP_SAMPLE);
    assign idsel_s = (ir_active_r == OP_IDCODE);

    // TAP state register.
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            state_r <= TLR;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode and chain/pin controls from the current state.
    always_comb begin
        state_nxt_s = TLR;
        tdo         = 1'b0;
        tdo_oe      = 1'b0;
        bs_scan_in  = tdi;
        bs_shift    = 1'b0;
        bs_clock_en = 1'b0;
        bs_update   = 1'b0;
        bs_test     = 1'b0;

        case (state_r)
            TLR:      state_nxt_s = tms ? TLR      : RTI;
            RTI:      state_nxt_s = tms ? SEL_DR   : RTI;
            SEL_DR:   state_nxt_s = tms ? SEL_IR   : CAP_DR;
            CAP_DR:   state_nxt_s = tms ? EXIT1_DR : SHIFT_DR;
            SHIFT_DR: state_nxt_s = tms ? EXIT1_DR : SHIFT_DR;
            EXIT1_DR: state_nxt_s = tms ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: state_nxt_s = tms ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR: state_nxt_s = tms ? UPD_DR   : SHIFT_DR;
            UPD_DR:   state_nxt_s = tms ? SEL_DR   : RTI;
            SEL_IR:   state_nxt_s = tms ? TLR      : CAP_IR;
            CAP_IR:   state_nxt_s = tms ? EXIT1_IR : SHIFT_IR;
            SHIFT_IR: state_nxt_s = tms ? EXIT1_IR : SHIFT_IR;
            EXIT1_IR: state_nxt_s = tms ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: state_nxt_s = tms ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR: state_nxt_s = tms ? UPD_IR   : SHIFT_IR;
            UPD_IR:   state_nxt_s = tms ? SEL_DR   : RTI;
            default:  state_nxt_s = TLR;
        endcase

        if (state_r == SHIFT_IR) begin
            tdo    = ir_shift_r[0];
            tdo_oe = 1'b1;
        end else if (state_r == SHIFT_DR) begin
            tdo_oe = 1'b1;
            if (bsel_s) begin
                tdo = bs_scan_out;
            end else if (idsel_s) begin
                tdo = idreg_r[0];
            end else begin
                tdo = bypass_r;
            end
        end else begin
            tdo    = 1'b0;
            tdo_oe = 1'b0;
        end

        bs_clock_en = bsel_s && ((state_r == CAP_DR) || (state_r == SHIFT_DR));
        bs_shift    = bsel_s && (state_r == SHIFT_DR);
        bs_update   = bsel_s && (state_r == UPD_DR);
        bs_test     = (ir_active_r == OP_EXTEST) && (state_r != TLR);
    end

    // Instruction shift and active registers; ir_active only changes in UPD_IR or TLR.
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            ir_shift_r  <= '0;
            ir_active_r <= OP_IDCODE;
        end else begin
            case (state_r)
                TLR:      ir_active_r <= OP_IDCODE;
                CAP_IR:   ir_shift_r  <= IR_CAPTURE;
                SHIFT_IR: ir_shift_r  <= {tdi, ir_shift_r[IR_WIDTH-1:1]};
                UPD_IR:   ir_active_r <= ir_shift_r;
                default:  begin end
            endcase
        end
    end

    // Internal data registers; the boundary register lives in the external chain.
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            bypass_r <= 1'b0;
            idreg_r  <= 32'h0000_0000;
        end else begin
            case (state_r)
                CAP_DR: begin
                    if (idsel_s) begin
                        idreg_r <= IDCODE_VALUE;
                    end else if (!bsel_s) begin
                        bypass_r <= 1'b0;
                    end
                end
                SHIFT_DR: begin
                    if (idsel_s) begin
                        idreg_r <= {tdi, idreg_r[31:1]};
                    end else if (!bsel_s) begin
                        bypass_r <= tdi;
                    end
                end
                default: begin end
            endcase
        end
    end

endmodule

// File: tb/tb_bscan_tap_ctrl.sv
// Self-checking bench for bscan_tap_ctrl: directed scans plus a random TMS/TDI walk
// compared against a table-driven TAP model; an 8-cell boundary chain stands in for the chip.
module tb_bscan_tap_ctrl;

    logic clock = 1'b0;
    logic reset_l;
    logic tms;
    logic tdi;
    logic tdo;
    logic tdo_oe;
    logic bs_scan_in;
    logic bs_scan_out;
    logic bs_shift;
    logic bs_clock_en;
    logic bs_update;
    logic bs_test;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [31:0] idv = 32'h1876_5001;
    logic [7:0]  cap_val = 8'hA5;

    bscan_tap_ctrl dut (
        .clock       (clock),
        .reset_l     (reset_l),
        .tms         (tms),
        .tdi         (tdi),
        .tdo         (tdo),
        .tdo_oe      (tdo_oe),
        .bs_scan_in  (bs_scan_in),
        .bs_scan_out (bs_scan_out),
        .bs_shift    (bs_shift),
        .bs_clock_en (bs_clock_en),
        .bs_update   (bs_update),
        .bs_test     (bs_test)
    );

    always #5 clock = ~clock;

    // Stand-in boundary chain: capture loads a fixed pattern, shift moves toward bit 0.
    logic [7:0] chain;
    logic [7:0] upd_reg;
    always @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            chain   <= 8'h00;
            upd_reg <= 8'h00;
        end else begin
            if (bs_clock_en) chain <= bs_shift ? {bs_scan_in, chain[7:1]} : cap_val;
            if (bs_update) upd_reg <= chain;
        end
    end
    assign bs_scan_out = chain[0];

    // ---------------- reference model (IEEE state codes, transition tables) ----------------
    localparam int S_EXIT2_DR = 0,  S_EXIT1_DR = 1,  S_SHIFT_DR = 2,  S_PAUSE_DR = 3;
    localparam int S_SEL_IR   = 4,  S_UPD_DR   = 5,  S_CAP_DR   = 6,  S_SEL_DR   = 7;
    localparam int S_EXIT2_IR = 8,  S_EXIT1_IR = 9,  S_SHIFT_IR = 10, S_PAUSE_IR = 11;
    localparam int S_RTI      = 12, S_UPD_IR   = 13, S_CAP_IR   = 14, S_TLR      = 15;

    int nxt0[16];
    int nxt1[16];
    int ms;
    logic [3:0]  m_ir_sh;
    logic [3:0]  m_ir_act;
    logic [31:0] m_id;
    logic        m_byp;
    logic e_tdo, e_oe, e_ce, e_sh, e_up, e_test;

    task automatic init_tables();
        nxt0[S_TLR] = S_RTI;           nxt1[S_TLR] = S_TLR;
        nxt0[S_RTI] = S_RTI;           nxt1[S_RTI] = S_SEL_DR;
        nxt0[S_SEL_DR] = S_CAP_DR;     nxt1[S_SEL_DR] = S_SEL_IR;
        nxt0[S_SEL_IR] = S_CAP_IR;     nxt1[S_SEL_IR] = S_TLR;
        nxt0[S_CAP_DR] = S_SHIFT_DR;   nxt1[S_CAP_DR] = S_EXIT1_DR;
        nxt0[S_SHIFT_DR] = S_SHIFT_DR; nxt1[S_SHIFT_DR] = S_EXIT1_DR;
        nxt0[S_EXIT1_DR] = S_PAUSE_DR; nxt1[S_EXIT1_DR] = S_UPD_DR;
        nxt0[S_PAUSE_DR] = S_PAUSE_DR; nxt1[S_PAUSE_DR] = S_EXIT2_DR;
        nxt0[S_EXIT2_DR] = S_SHIFT_DR; nxt1[S_EXIT2_DR] = S_UPD_DR;
        nxt0[S_UPD_DR] = S_RTI;        nxt1[S_UPD_DR] = S_SEL_DR;
        nxt0[S_CAP_IR] = S_SHIFT_IR;   nxt1[S_CAP_IR] = S_EXIT1_IR;
        nxt0[S_SHIFT_IR] = S_SHIFT_IR; nxt1[S_SHIFT_IR] = S_EXIT1_IR;
        nxt0[S_EXIT1_IR] = S_PAUSE_IR; nxt1[S_EXIT1_IR] = S_UPD_IR;
        nxt0[S_PAUSE_IR] = S_PAUSE_IR; nxt1[S_PAUSE_IR] = S_EXIT2_IR;
        nxt0[S_EXIT2_IR] = S_SHIFT_IR; nxt1[S_EXIT2_IR] = S_UPD_IR;
        nxt0[S_UPD_IR] = S_RTI;        nxt1[S_UPD_IR] = S_SEL_DR;
    endtask

    task automatic model_reset();
        ms       = S_TLR;
        m_ir_sh  = 4'b0000;
        m_ir_act = 4'b0010;
        m_id     = 32'h0;
        m_byp    = 1'b0;
    endtask

    task automatic model_eval();
        bit is_bnd, is_id;
        is_bnd = (m_ir_act == 4'b0000) || (m_ir_act == 4'b0001);
        is_id  = (m_ir_act == 4'b0010);
        e_tdo  = 1'b0;
        if (ms == S_SHIFT_IR) e_tdo = m_ir_sh[0];
        else if (ms == S_SHIFT_DR) e_tdo = is_bnd ? bs_scan_out : (is_id ? m_id[0] : m_byp);
        e_oe   = (ms == S_SHIFT_IR) || (ms == S_SHIFT_DR);
        e_ce   = is_bnd && ((ms == S_CAP_DR) || (ms == S_SHIFT_DR));
        e_sh   = is_bnd && (ms == S_SHIFT_DR);
        e_up   = is_bnd && (ms == S_UPD_DR);
        e_test = (m_ir_act == 4'b0000) && (ms != S_TLR);
    endtask

    task automatic model_advance(input logic t, input logic d);
        bit is_bnd, is_id;
        is_bnd = (m_ir_act == 4'b0000) || (m_ir_act == 4'b0001);
        is_id  = (m_ir_act == 4'b0010);
        if (ms == S_TLR) m_ir_act = 4'b0010;
        else if (ms == S_CAP_IR) m_ir_sh = 4'b0001;
        else if (ms == S_SHIFT_IR) m_ir_sh = {d, m_ir_sh[3:1]};
        else if (ms == S_UPD_IR) m_ir_act = m_ir_sh;
        else if (ms == S_CAP_DR) begin
            if (is_id) m_id = idv;
            else if (!is_bnd) m_byp = 1'b0;
        end else if (ms == S_SHIFT_DR) begin
            if (is_id) m_id = {d, m_id[31:1]};
            else if (!is_bnd) m_byp = d;
        end
        ms = t ? nxt1[ms] : nxt0[ms];
    endtask

    // One TCK: drive pins after the falling edge, settle, snapshot model expectations.
    task automatic step(input logic t, input logic d);
        @(negedge clock);
        tms = t;
        tdi = d;
        #1;
        model_eval();
        model_advance(t, d);
    endtask

    task automatic ir_scan(input logic [3:0] op);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(i == 3, op[i]);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clock);
        reset_l = 1'b0;
        tms = 1'b1;
        tdi = 1'b1;
        model_reset();
        #2;
        total_cnt++; if (tdo !== 1'b0) $display("FAIL reset_tdo got %b want 0", tdo); else pass_cnt++;
        total_cnt++; if (tdo_oe !== 1'b0) $display("FAIL reset_tdo_oe got %b want 0", tdo_oe); else pass_cnt++;
        total_cnt++; if ({bs_shift, bs_clock_en, bs_update, bs_test} !== 4'b0000)
            $display("FAIL reset_bs got %b want 0000", {bs_shift, bs_clock_en, bs_update, bs_test}); else pass_cnt++;
        @(negedge clock);
        reset_l = 1'b1;
        step(1'b1, 1'b1);
        total_cnt++; if ({tdo_oe, bs_shift, bs_clock_en, bs_update, bs_test} !== 5'b00000)
            $display("FAIL tlr_outputs got %b want 00000", {tdo_oe, bs_shift, bs_clock_en, bs_update, bs_test}); else pass_cnt++;
        step(1'b0, 1'b0);
    endtask

    task automatic test_idcode();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 32; i++) begin
            step(i == 31, 1'($urandom_range(0, 1)));
            total_cnt++; if (tdo !== idv[i] || tdo_oe !== 1'b1)
                $display("FAIL idcode_bit%0d got tdo=%b oe=%b want tdo=%b oe=1", i, tdo, tdo_oe, idv[i]); else pass_cnt++;
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic test_bypass();
        logic [3:0] ir_exp = 4'b0001;
        logic [3:0] pat = 4'b1101;
        logic want;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(i == 3, 1'b1);
            total_cnt++; if (tdo !== ir_exp[i])
                $display("FAIL ir_capture_bit%0d got %b want %b", i, tdo, ir_exp[i]); else pass_cnt++;
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(i == 3, pat[i]);
            want = (i == 0) ? 1'b0 : pat[i-1];
            total_cnt++; if (tdo !== want)
                $display("FAIL bypass_bit%0d got %b want %b", i, tdo, want); else pass_cnt++;
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic test_extest();
        logic [7:0] pat;
        int ce = 0, sh = 0, up = 0;
        pat = 8'($urandom);
        ir_scan(4'b0000);
        total_cnt++; if (bs_test !== 1'b0) $display("FAIL bs_test_in_upd_ir got %b want 0", bs_test); else pass_cnt++;
        step(1'b1, 1'b0);
        total_cnt++; if (bs_test !== 1'b1) $display("FAIL bs_test_after_upd_ir got %b want 1", bs_test); else pass_cnt++;
        ce += int'(bs_clock_en); sh += int'(bs_shift); up += int'(bs_update);
        step(1'b0, 1'b0);
        ce += int'(bs_clock_en); sh += int'(bs_shift); up += int'(bs_update);
        step(1'b0, 1'b0);
        ce += int'(bs_clock_en); sh += int'(bs_shift); up += int'(bs_update);
        for (int i = 0; i < 8; i++) begin
            step(i == 7, pat[i]);
            ce += int'(bs_clock_en); sh += int'(bs_shift); up += int'(bs_update);
            total_cnt++; if (tdo !== cap_val[i] || bs_scan_in !== pat[i])
                $display("FAIL extest_shift%0d got tdo=%b scan_in=%b want %b %b", i, tdo, bs_scan_in, cap_val[i], pat[i]); else pass_cnt++;
        end
        step(1'b1, 1'b0);
        ce += int'(bs_clock_en); sh += int'(bs_shift); up += int'(bs_update);
        step(1'b0, 1'b0);
        ce += int'(bs_clock_en); sh += int'(bs_shift); up += int'(bs_update);
        step(1'b0, 1'b0);
        ce += int'(bs_clock_en); sh += int'(bs_shift); up += int'(bs_update);
        total_cnt++; if (ce != 9) $display("FAIL clock_en_cycles got %0d want 9", ce); else pass_cnt++;
        total_cnt++; if (sh != 8) $display("FAIL shift_cycles got %0d want 8", sh); else pass_cnt++;
        total_cnt++; if (up != 1) $display("FAIL update_pulses got %0d want 1", up); else pass_cnt++;
        total_cnt++; if (upd_reg !== pat) $display("FAIL chain_update got %h want %h", upd_reg, pat); else pass_cnt++;
        // DR scan through PAUSE_DR: chain must hold in exit/pause states.
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step((i == 3) ? 1'b1 : 1'b0, 1'b0);
            total_cnt++; if (bs_clock_en !== 1'b0)
                $display("FAIL pause_hold%0d got clock_en=%b want 0", i, bs_clock_en); else pass_cnt++;
        end
        step(1'b1, 1'b0);
        total_cnt++; if (bs_clock_en !== 1'b1) $display("FAIL resume_shift got clock_en=%b want 1", bs_clock_en); else pass_cnt++;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic test_tlr_escape();
        int up = 0;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0);
            up += int'(bs_update);
        end
        total_cnt++; if (up != 1) $display("FAIL escape_updates got %0d want 1", up); else pass_cnt++;
        step(1'b0, 1'b0);
        total_cnt++; if (bs_test !== 1'b0 || tdo_oe !== 1'b0)
            $display("FAIL escape_tlr got test=%b oe=%b want 0 0", bs_test, tdo_oe); else pass_cnt++;
        step(1'b1, 1'b0);
        total_cnt++; if (bs_test !== 1'b0) $display("FAIL escape_rti_test got %b want 0", bs_test); else pass_cnt++;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        total_cnt++; if (tdo !== 1'b1 || bs_shift !== 1'b0)
            $display("FAIL escape_idcode got tdo=%b shift=%b want 1 0", tdo, bs_shift); else pass_cnt++;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_shift();
        ir_scan(4'b1111);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        total_cnt++; if (tdo_oe !== 1'b1) $display("FAIL mid_shift_oe got %b want 1", tdo_oe); else pass_cnt++;
        #2;
        reset_l = 1'b0;
        model_reset();
        #1;
        total_cnt++; if (tdo_oe !== 1'b0 || bs_test !== 1'b0)
            $display("FAIL async_reset got oe=%b test=%b want 0 0", tdo_oe, bs_test); else pass_cnt++;
        @(negedge clock);
        reset_l = 1'b1;
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(i == 3, 1'b0);
            total_cnt++; if (tdo !== idv[i])
                $display("FAIL post_reset_idcode%0d got %b want %b", i, tdo, idv[i]); else pass_cnt++;
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic t, d;
        for (int n = 0; n < 1500; n++) begin
            t = ($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0;
            d = 1'($urandom_range(0, 1));
            step(t, d);
            total_cnt++; if ({tdo, tdo_oe, bs_scan_in, bs_shift, bs_clock_en, bs_update, bs_test} !==
                             {e_tdo, e_oe, d, e_sh, e_ce, e_up, e_test})
                $display("FAIL random_cycle%0d got %b want %b", n,
                         {tdo, tdo_oe, bs_scan_in, bs_shift, bs_clock_en, bs_update, bs_test},
                         {e_tdo, e_oe, d, e_sh, e_ce, e_up, e_test});
            else pass_cnt++;
        end
    endtask

    initial begin
        reset_l = 1'b1;
        tms = 1'b1;
        tdi = 1'b0;
        init_tables();
        model_reset();
        test_reset();
        test_idcode();
        test_bypass();
        test_extest();
        test_tlr_escape();
        test_reset_mid_shift();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
